// File: rtl/user_io_pkg.sv
// Shared types, register offsets and byte-lane helpers for the user IO bank.
package user_io_pkg;

    typedef logic [1:0] io_mode_t;

    localparam io_mode_t MODE_CORE     = 2'b00;
    localparam io_mode_t MODE_GPIO_OUT = 2'b01;
    localparam io_mode_t MODE_GPIO_IN  = 2'b10;
    localparam io_mode_t MODE_HIZ      = 2'b11;

    localparam logic [7:0] REG_OUT_LO      = 8'h00;
    localparam logic [7:0] REG_OUT_HI      = 8'h04;
    localparam logic [7:0] REG_IN_LO       = 8'h08;
    localparam logic [7:0] REG_IN_HI       = 8'h0C;
    localparam logic [7:0] REG_MODE0       = 8'h10;
    localparam logic [7:0] REG_MODE1       = 8'h14;
    localparam logic [7:0] REG_MODE2       = 8'h18;
    localparam logic [7:0] REG_MODE3       = 8'h1C;
    localparam logic [7:0] REG_IRQ_EN_LO   = 8'h20;
    localparam logic [7:0] REG_IRQ_EN_HI   = 8'h24;
    localparam logic [7:0] REG_IRQ_STAT_LO = 8'h28;
    localparam logic [7:0] REG_IRQ_STAT_HI = 8'h2C;

    function automatic logic [31:0] byte_mask_f(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] wr_merge_f(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] m;
        m = byte_mask_f(sel);
        return (old_v & ~m) | (new_v & m);
    endfunction

    function automatic logic [63:0] io_mask_f(input int n);
        logic [63:0] m;
        for (int i = 0; i < 64; i++) begin
            m[i] = (i < n) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

    function automatic logic [127:0] mode_mask_f(input int n);
        logic [127:0] m;
        for (int i = 0; i < 64; i++) begin
            m[2*i +: 2] = (i < n) ? 2'b11 : 2'b00;
        end
        return m;
    endfunction

endpackage

// File: rtl/user_io_pin_mux.sv
// Per-pad combinational mode mux: core passthrough, GPIO out, GPIO in or hi-z.
module user_io_pin_mux
    import user_io_pkg::*;
(
    input  io_mode_t mode_i,
    input  logic     core_out_i,
    input  logic     core_oeb_i,
    input  logic     gpio_out_i,
    output logic     pad_out_o,
    output logic     pad_oeb_o
);

    // Select pad drive according to the programmed mode
    always_comb begin
        pad_out_o = 1'b0;
        pad_oeb_o = 1'b1;
        case (mode_i)
            MODE_CORE: begin
                pad_out_o = core_out_i;
                pad_oeb_o = core_oeb_i;
            end
            MODE_GPIO_OUT: begin
                pad_out_o = gpio_out_i;
                pad_oeb_o = 1'b0;
            end
            MODE_GPIO_IN: begin
                pad_out_o = 1'b0;
                pad_oeb_o = 1'b1;
            end
            MODE_HIZ: begin
                pad_out_o = 1'b0;
                pad_oeb_o = 1'b1;
            end
            default: begin
                pad_out_o = 1'b0;
                pad_oeb_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/user_io_bank.sv
// Wishbone-programmable pad bank between the user core and the Caravel IO pins.
// Optional rising-edge interrupts are built when USER_IO_BANK_IRQ_EN is defined.
module user_io_bank
    import user_io_pkg::*;
#(
    parameter int          NUM_IO   = 38,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          IRQ_LINE = 0
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [NUM_IO-1:0] io_in,
    output logic [NUM_IO-1:0] io_out,
    output logic [NUM_IO-1:0] io_oeb,
    output logic [NUM_IO-1:0] core_io_in,
    input  logic [NUM_IO-1:0] core_io_out,
    input  logic [NUM_IO-1:0] core_io_oeb,
    output logic [2:0]        user_irq
);

    localparam logic [63:0]  IO_MASK   = io_mask_f(NUM_IO);
    localparam logic [127:0] MODE_MASK = mode_mask_f(NUM_IO);

    logic              req_s, wr_s;
    logic [7:0]        reg_off_s;
    logic [31:0]       rdata_s;
    logic [63:0]       in_ext_s;
    logic              unused_s;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic [63:0]       out_q, out_d;
    logic [127:0]      mode_q, mode_d;
    logic [NUM_IO-1:0] sync1_q, sync1_d;
    logic [NUM_IO-1:0] in_q, in_d;

    assign req_s     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign reg_off_s = {wbs_adr_i[7:2], 2'b00};
    // The write lands on the edge that closes the ack cycle, so a reset during ack discards it
    assign wr_s      = ack_q & req_s & wbs_we_i;
    assign in_ext_s  = 64'(in_q);
    assign unused_s  = ^wbs_adr_i[1:0];

    assign core_io_in = io_in;
    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;

`ifdef USER_IO_BANK_IRQ_EN
    logic [63:0]       irq_en_q, irq_en_d;
    logic [63:0]       irq_stat_q, irq_stat_d;
    logic [NUM_IO-1:0] in_prev_q, in_prev_d;
    logic              irq_q, irq_d;
    logic [63:0]       rise_s;
    logic [2:0]        user_irq_s;

    assign rise_s = 64'(in_q & ~in_prev_q);

    // Interrupt enable/status next state; a fresh edge overrides a same-cycle clear
    always_comb begin
        irq_en_d   = irq_en_q;
        irq_stat_d = irq_stat_q;
        in_prev_d  = in_q;
        irq_d      = |(irq_stat_q & irq_en_q);
        if (wr_s) begin
            case (reg_off_s)
                REG_IRQ_EN_LO:   irq_en_d[31:0]    = wr_merge_f(irq_en_q[31:0], wbs_dat_i, wbs_sel_i);
                REG_IRQ_EN_HI:   irq_en_d[63:32]   = wr_merge_f(irq_en_q[63:32], wbs_dat_i, wbs_sel_i);
                REG_IRQ_STAT_LO: irq_stat_d[31:0]  = irq_stat_q[31:0] & ~(wbs_dat_i & byte_mask_f(wbs_sel_i));
                REG_IRQ_STAT_HI: irq_stat_d[63:32] = irq_stat_q[63:32] & ~(wbs_dat_i & byte_mask_f(wbs_sel_i));
                default:         irq_en_d          = irq_en_q;
            endcase
        end else begin
            irq_en_d = irq_en_q;
        end
        irq_en_d   = irq_en_d & IO_MASK;
        irq_stat_d = (irq_stat_d | rise_s) & IO_MASK;
    end

    // Interrupt state registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_en_q   <= 64'h0;
            irq_stat_q <= 64'h0;
            in_prev_q  <= {NUM_IO{1'b0}};
            irq_q      <= 1'b0;
        end else begin
            irq_en_q   <= irq_en_d;
            irq_stat_q <= irq_stat_d;
            in_prev_q  <= in_prev_d;
            irq_q      <= irq_d;
        end
    end

    // Route the registered interrupt onto the configured line
    always_comb begin
        user_irq_s           = 3'b000;
        user_irq_s[IRQ_LINE] = irq_q;
    end

    assign user_irq = user_irq_s;
`else
    assign user_irq = 3'b000;
`endif

    // Register read mux; unmapped in-window offsets read zero
    always_comb begin
        rdata_s = 32'h0;
        case (reg_off_s)
            REG_OUT_LO:      rdata_s = out_q[31:0];
            REG_OUT_HI:      rdata_s = out_q[63:32];
            REG_IN_LO:       rdata_s = in_ext_s[31:0];
            REG_IN_HI:       rdata_s = in_ext_s[63:32];
            REG_MODE0:       rdata_s = mode_q[31:0];
            REG_MODE1:       rdata_s = mode_q[63:32];
            REG_MODE2:       rdata_s = mode_q[95:64];
            REG_MODE3:       rdata_s = mode_q[127:96];
`ifdef USER_IO_BANK_IRQ_EN
            REG_IRQ_EN_LO:   rdata_s = irq_en_q[31:0];
            REG_IRQ_EN_HI:   rdata_s = irq_en_q[63:32];
            REG_IRQ_STAT_LO: rdata_s = irq_stat_q[31:0];
            REG_IRQ_STAT_HI: rdata_s = irq_stat_q[63:32];
`endif
            default:         rdata_s = 32'h0;
        endcase
    end

    // Handshake, write commit and input synchroniser next state
    always_comb begin
        ack_d   = req_s & ~ack_q;
        sync1_d = io_in;
        in_d    = sync1_q;
        out_d   = out_q;
        mode_d  = mode_q;
        if (ack_d) begin
            dat_d = rdata_s;
        end else begin
            dat_d = 32'h0;
        end
        if (wr_s) begin
            case (reg_off_s)
                REG_OUT_LO: out_d[31:0]    = wr_merge_f(out_q[31:0], wbs_dat_i, wbs_sel_i);
                REG_OUT_HI: out_d[63:32]   = wr_merge_f(out_q[63:32], wbs_dat_i, wbs_sel_i);
                REG_MODE0:  mode_d[31:0]   = wr_merge_f(mode_q[31:0], wbs_dat_i, wbs_sel_i);
                REG_MODE1:  mode_d[63:32]  = wr_merge_f(mode_q[63:32], wbs_dat_i, wbs_sel_i);
                REG_MODE2:  mode_d[95:64]  = wr_merge_f(mode_q[95:64], wbs_dat_i, wbs_sel_i);
                REG_MODE3:  mode_d[127:96] = wr_merge_f(mode_q[127:96], wbs_dat_i, wbs_sel_i);
                default:    out_d          = out_q;
            endcase
        end else begin
            out_d = out_q;
        end
        out_d  = out_d & IO_MASK;
        mode_d = mode_d & MODE_MASK;
    end

    // Core state registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q   <= 1'b0;
            dat_q   <= 32'h0;
            out_q   <= 64'h0;
            mode_q  <= 128'h0;
            sync1_q <= {NUM_IO{1'b0}};
            in_q    <= {NUM_IO{1'b0}};
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
            sync1_q <= sync1_d;
            in_q    <= in_d;
        end
    end

    for (genvar i = 0; i < NUM_IO; i++) begin : g_pin
        user_io_pin_mux u_mux (
            .mode_i     (mode_q[2*i +: 2]),
            .core_out_i (core_io_out[i]),
            .core_oeb_i (core_io_oeb[i]),
            .gpio_out_i (out_q[i]),
            .pad_out_o  (io_out[i]),
            .pad_oeb_o  (io_oeb[i])
        );
    end

endmodule

// File: tb/tb_user_io_bank.sv
// Directed self-checking bench for user_io_bank (default NUM_IO=38, IRQ_LINE=0).
module tb_user_io_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic        ack;
    logic [31:0] rdat_o;
    logic [37:0] io_in = 38'h0;
    logic [37:0] io_out, io_oeb, core_io_in;
    logic [37:0] core_io_out = 38'h15_5555_5555;
    logic [37:0] core_io_oeb = 38'h0;
    logic [2:0]  user_irq;

    int total = 0;
    int bad = 0;

    localparam logic [31:0] B = 32'h3000_0000;

    user_io_bank dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .core_io_in(core_io_in),
        .core_io_out(core_io_out), .core_io_oeb(core_io_oeb), .user_irq(user_irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the commit edge
    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] r);
        int n;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        n = 0;
        r = 32'h0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 16);
        if (!ack) check_eq("ack_timeout", 64'(ack), 64'h1);
        else r = rdat_o;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_cycle(B | 32'(off), 1'b1, d, s, dummy);
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] r);
        wb_cycle(B | 32'(off), 1'b0, 32'h0, 4'hF, r);
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  pat;
        logic [31:0] held_dat, gap_dat;
        logic        any_ack;

        #12;
        check_eq("rst_io_out", 64'(io_out), 64'h15_5555_5555);
        check_eq("rst_io_oeb", 64'(io_oeb), 64'h0);
        check_eq("rst_dat", 64'(rdat_o), 64'h0);
        check_eq("rst_ack", 64'(ack), 64'h0);
        check_eq("rst_irq", 64'(user_irq), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        rd(8'h10, r);
        check_eq("mode0_rst", 64'(r), 64'h0);

        // Pin 0 to gpio_out with OUT=0 first, then OUT=1
        wr(8'h10, 32'h1, 4'hF);
        check_eq("pin0_out0", 64'(io_out[0]), 64'h0);
        check_eq("pin0_oeb", 64'(io_oeb[0]), 64'h0);
        wr(8'h00, 32'h1, 4'hF);
        check_eq("pin0_out1", 64'(io_out[0]), 64'h1);
        check_eq("pins_core", 64'(io_out[37:1]), 64'(core_io_out[37:1]));

        // Pin 5 to gpio_in; check two-flop input latency
        wr(8'h10, 32'h0000_0801, 4'hF);
        check_eq("pin5_oeb", 64'(io_oeb[5]), 64'h1);
        io_in[5] = 1'b1;
        #1 check_eq("core_io_in", 64'(core_io_in), 64'h20);
        @(negedge clk);
        rd(8'h08, r);
        check_eq("in_lo_early", 64'(r), 64'h0);
        rd(8'h08, r);
        check_eq("in_lo_late", 64'(r), 64'h20);

        // Byte-lane writes and bits above NUM_IO
        wr(8'h00, 32'hFFFF_FFFF, 4'b0001);
        rd(8'h00, r);
        check_eq("out_lo_byte", 64'(r), 64'hFF);
        wr(8'h04, 32'hFFFF_FFFF, 4'hF);
        rd(8'h04, r);
        check_eq("out_hi_mask", 64'(r), 64'h3F);
        wr(8'h18, 32'hFFFF_FFFF, 4'hF);
        rd(8'h18, r);
        check_eq("mode2_mask", 64'(r), 64'hFFF);
        wr(8'h1C, 32'hFFFF_FFFF, 4'hF);
        rd(8'h1C, r);
        check_eq("mode3_mask", 64'(r), 64'h0);
        check_eq("pin32_hiz_oeb", 64'(io_oeb[32]), 64'h1);

        // Held strobe: ack on alternate cycles, data zero between acks
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = B | 32'h04; sel = 4'hF;
        pat = 4'h0; held_dat = 32'h0; gap_dat = 32'hDEAD;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pat = {pat[2:0], ack};
            if (k == 0) held_dat = rdat_o;
            if (k == 1) gap_dat = rdat_o;
        end
        cyc = 1'b0; stb = 1'b0;
        check_eq("ack_pattern", 64'(pat), 64'hA);
        check_eq("held_dat", 64'(held_dat), 64'h3F);
        check_eq("gap_dat", 64'(gap_dat), 64'h0);
        @(negedge clk);

        // Address outside the window gets no ack
        cyc = 1'b1; stb = 1'b1; adr = B | 32'h100;
        any_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            any_ack = any_ack | ack;
        end
        cyc = 1'b0; stb = 1'b0;
        check_eq("miss_no_ack", 64'(any_ack), 64'h0);
        @(negedge clk);

`ifdef USER_IO_BANK_IRQ_EN
        // Edge on pin 5 earlier latched STAT even with EN=0
        rd(8'h28, r);
        check_eq("stat_latched", 64'(r), 64'h20);
        wr(8'h20, 32'h20, 4'hF);
        rd(8'h20, r);
        check_eq("irq_en_rd", 64'(r), 64'h20);
        check_eq("irq_on", 64'(user_irq), 64'h1);
        wr(8'h28, 32'h20, 4'hF);
        check_eq("irq_hold", 64'(user_irq), 64'h1);
        @(negedge clk);
        check_eq("irq_fall", 64'(user_irq), 64'h0);
        rd(8'h28, r);
        check_eq("stat_clr", 64'(r), 64'h0);
        io_in[5] = 1'b0;
        repeat (4) @(negedge clk);
        // New edge reaches STAT on the same edge the clear commits
        io_in[5] = 1'b1;
        @(negedge clk);
        wr(8'h28, 32'h20, 4'hF);
        rd(8'h28, r);
        check_eq("set_wins", 64'(r), 64'h20);
        check_eq("irq_again", 64'(user_irq), 64'h1);
`else
        wr(8'h20, 32'h20, 4'hF);
        rd(8'h20, r);
        check_eq("irq_en_absent", 64'(r), 64'h0);
        rd(8'h28, r);
        check_eq("irq_stat_absent", 64'(r), 64'h0);
        check_eq("irq_absent", 64'(user_irq), 64'h0);
`endif

        // Reset during a write's ack cycle
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = B; wdat = 32'h5A5A_5A5A; sel = 4'hF;
        any_ack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!any_ack) begin
                @(negedge clk);
                any_ack = ack;
            end
        end
        check_eq("rst_wr_ack_seen", 64'(any_ack), 64'h1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_ack_drop", 64'(ack), 64'h0);
        check_eq("rst_dat_drop", 64'(rdat_o), 64'h0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(8'h00, r);
        check_eq("rst_wr_discard", 64'(r), 64'h0);
        check_eq("rst_transparent", 64'(io_out), 64'h15_5555_5555);
        rd(8'h40, r);
        check_eq("unmapped_rd", 64'(r), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
